// File: rtl/cnn_pkg.sv
// Shared stage codes and sequencer state type for the CNN layer datapath.
// Used by the layer sequencer, the layer controller and the host register block.
package cnn_pkg;

  // Stage codes driven on ctrl and echoed back on return_ctrl.
  localparam logic [7:0] ST_IDLE  = 8'd0;
  localparam logic [7:0] ST_IMG   = 8'd1;
  localparam logic [7:0] ST_CONV1 = 8'd2;
  localparam logic [7:0] ST_POOL1 = 8'd3;
  localparam logic [7:0] ST_CONV2 = 8'd4;
  localparam logic [7:0] ST_POOL2 = 8'd5;
  localparam logic [7:0] ST_FC    = 8'd6;

  localparam int unsigned NUM_STAGES = 6;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone,
    StError
  } seq_state_t;

endpackage

// File: rtl/cnn_stage_timer.sv
// Cycle counter with clear, enable, saturation at all-ones and a limit compare.
// Clear has priority over enable.
module cnn_stage_timer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             at_limit
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: clear, else increment while enabled and not saturated.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign at_limit = (count_q == limit);

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Steps the layer controller's ctrl code through image load, conv1, pool1, conv2,
// pool2 and FC, advancing when return_ctrl echoes the current code.
// Optional per-stage cycle counters are built when CNN_SEQ_PERF_EN is defined.
module cnn_layer_sequencer
  import cnn_pkg::*;
#(
  parameter int unsigned LAST_STAGE     = 6,
  parameter int unsigned TIMEOUT_CYCLES = 32'd1_000_000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             img_ready,
  input  logic [7:0]       return_ctrl,
`ifdef CNN_SEQ_PERF_EN
  input  logic [2:0]       perf_sel,
  output logic [CNT_W-1:0] perf_count,
`endif
  output logic [7:0]       ctrl,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [2:0]       err_stage
);

  localparam logic [7:0]       LastCode     = 8'(LAST_STAGE);
  localparam bit               TimeoutEn    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TimeoutLimit =
      (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  seq_state_t state_q, state_d;
  logic [7:0] ctrl_q, ctrl_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       error_q, error_d;
  logic [2:0] err_stage_q, err_stage_d;

  logic             advance;
  logic             stage_timeout;
  logic [CNT_W-1:0] unused_stage_count;

  // Stage 1 additionally waits for the host to finish loading the image.
  // A stale or unexpected echo simply counts as "not done".
  assign advance = (state_q == StRun) && (return_ctrl == ctrl_q) &&
                   ((ctrl_q != ST_IMG) || img_ready);

  cnn_stage_timer #(
    .CNT_W(CNT_W)
  ) u_stage_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   ((state_q != StRun) || advance),
    .enable  (state_q == StRun),
    .limit   (TimeoutLimit),
    .count   (unused_stage_count),
    .at_limit(stage_timeout)
  );

  // Next-state and registered-output decode; abort overrides everything.
  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    err_stage_d = err_stage_q;
    if (abort) begin
      state_d = StIdle;
      ctrl_d  = ST_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      error_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone, StError: begin
          if (start) begin
            state_d = StRun;
            ctrl_d  = ST_IMG;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            error_d = 1'b0;
          end
        end
        StRun: begin
          if (advance) begin
            if (ctrl_q < LastCode) begin
              ctrl_d = ctrl_q + 8'd1;
            end else begin
              // ctrl stays at the last code so results remain readable.
              state_d = StDone;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end
          end else if (TimeoutEn && stage_timeout) begin
            state_d     = StError;
            error_d     = 1'b1;
            err_stage_d = ctrl_q[2:0];
            ctrl_d      = ST_IDLE;
            busy_d      = 1'b0;
          end
        end
        default: begin
          state_d = StIdle;
          ctrl_d  = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset forces ctrl to idle immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      ctrl_q      <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_stage_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_stage_q <= err_stage_d;
    end
  end

  assign ctrl      = ctrl_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_stage = err_stage_q;

`ifdef CNN_SEQ_PERF_EN
  logic [CNT_W-1:0]      perf_cnt [NUM_STAGES];
  logic [NUM_STAGES-1:0] unused_perf_limit;
  logic                  perf_clear;
  logic [CNT_W-1:0]      perf_count_q, perf_count_d;

  // Counters restart on every accepted start.
  assign perf_clear = start && !abort && (state_q != StRun);

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_perf
    cnn_stage_timer #(
      .CNT_W(CNT_W)
    ) u_perf_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (perf_clear),
      .enable  ((state_q == StRun) && (ctrl_q == 8'(g + 1))),
      .limit   ({CNT_W{1'b1}}),
      .count   (perf_cnt[g]),
      .at_limit(unused_perf_limit[g])
    );
  end

  // Readout mux; codes outside 1..6 read as zero.
  always_comb begin
    perf_count_d = '0;
    case (perf_sel)
      3'd1:    perf_count_d = perf_cnt[0];
      3'd2:    perf_count_d = perf_cnt[1];
      3'd3:    perf_count_d = perf_cnt[2];
      3'd4:    perf_count_d = perf_cnt[3];
      3'd5:    perf_count_d = perf_cnt[4];
      3'd6:    perf_count_d = perf_cnt[5];
      default: perf_count_d = '0;
    endcase
  end

  // Registered readout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_count_q <= '0;
    end else begin
      perf_count_q <= perf_count_d;
    end
  end

  assign perf_count = perf_count_q;
`endif

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench for cnn_layer_sequencer. Two instances share stimulus:
// dut_a has the timeout disabled, dut_t times out after 16 cycles in a stage.
// Each instance has its own echo model driving return_ctrl.
module tb_cnn_layer_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, abort, img_ready;
  logic [7:0] rc_a, rc_t, ctrl_a, ctrl_t;
  logic       busy_a, done_a, error_a, busy_t, done_t, error_t;
  logic [2:0] err_stage_a, err_stage_t;
`ifdef CNN_SEQ_PERF_EN
  logic [2:0]  perf_sel = 3'd0;
  logic [31:0] perf_count_a, perf_count_t;
`endif

  int checks = 0;
  int errors = 0;

  // Cycles the echo model waits in each stage before echoing ctrl.
  int stage_len [1:6];

  logic [7:0] last_a = 8'd0;
  logic [7:0] last_t = 8'd0;
  int         cnt_a = 0;
  int         cnt_t = 0;

  always #5 clk = ~clk;

  cnn_layer_sequencer #(
    .LAST_STAGE(6), .TIMEOUT_CYCLES(0), .CNT_W(32)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .img_ready(img_ready),
    .return_ctrl(rc_a),
`ifdef CNN_SEQ_PERF_EN
    .perf_sel(perf_sel), .perf_count(perf_count_a),
`endif
    .ctrl(ctrl_a), .busy(busy_a), .done(done_a), .error(error_a), .err_stage(err_stage_a)
  );

  cnn_layer_sequencer #(
    .LAST_STAGE(6), .TIMEOUT_CYCLES(16), .CNT_W(32)
  ) dut_t (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .img_ready(img_ready),
    .return_ctrl(rc_t),
`ifdef CNN_SEQ_PERF_EN
    .perf_sel(perf_sel), .perf_count(perf_count_t),
`endif
    .ctrl(ctrl_t), .busy(busy_t), .done(done_t), .error(error_t), .err_stage(err_stage_t)
  );

  // Controller model: returns ctrl-1 while a stage runs, ctrl once it has taken
  // stage_len[ctrl] cycles.
  function automatic logic [7:0] respond(input logic [7:0] c, input int n);
    if (c == 8'd0 || c > 8'd6) return 8'd0;
    if (n >= stage_len[c] - 1) return c;
    return c - 8'd1;
  endfunction

  always @(negedge clk) begin
    if (ctrl_a != last_a) cnt_a = 0; else cnt_a = cnt_a + 1;
    last_a = ctrl_a;
    rc_a   = respond(ctrl_a, cnt_a);
    if (ctrl_t != last_t) cnt_t = 0; else cnt_t = cnt_t + 1;
    last_t = ctrl_t;
    rc_t   = respond(ctrl_t, cnt_t);
  end

  task automatic set_lens(input int l1, l2, l3, l4, l5, l6);
    stage_len[1] = l1; stage_len[2] = l2; stage_len[3] = l3;
    stage_len[4] = l4; stage_len[5] = l5; stage_len[6] = l6;
  endtask

  task automatic pulse_start;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done_a(input int budget);
    int n = 0;
    while (!done_a && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_a !== 1'b1) begin
      errors++;
      $display("FAIL wait_done_a: done=%b after %0d cycles, required 1", done_a, n);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; abort = 1'b0; img_ready = 1'b0;
    set_lens(3, 3, 3, 3, 3, 3);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({ctrl_a, busy_a, done_a, error_a, err_stage_a} !== 14'd0) begin
      errors++;
      $display("FAIL reset_a: ctrl=%0d busy=%b done=%b error=%b err_stage=%0d, required all 0",
               ctrl_a, busy_a, done_a, error_a, err_stage_a);
    end
    checks++;
    if ({ctrl_t, busy_t, done_t, error_t, err_stage_t} !== 14'd0) begin
      errors++;
      $display("FAIL reset_t: ctrl=%0d busy=%b done=%b error=%b err_stage=%0d, required all 0",
               ctrl_t, busy_t, done_t, error_t, err_stage_t);
    end
  endtask

  task automatic test_happy_path;
    set_lens(3, 3, 3, 3, 3, 3);
    img_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 18; i++) begin
      checks++;
      if (ctrl_a !== 8'(i / 3 + 1)) begin
        errors++;
        $display("FAIL happy_ctrl cycle %0d: ctrl=%0d, required %0d", i, ctrl_a, i / 3 + 1);
      end
      if (i == 9) begin
        checks++;
        if ({busy_a, done_a} !== 2'b10) begin
          errors++;
          $display("FAIL happy_busy: busy=%b done=%b, required 1 0", busy_a, done_a);
        end
      end
      @(negedge clk);
    end
    checks++;
    if ({ctrl_a, busy_a, done_a, error_a} !== {8'd6, 3'b010}) begin
      errors++;
      $display("FAIL happy_done_a: ctrl=%0d busy=%b done=%b error=%b, required 6 0 1 0",
               ctrl_a, busy_a, done_a, error_a);
    end
    checks++;
    if ({ctrl_t, busy_t, done_t, error_t} !== {8'd6, 3'b010}) begin
      errors++;
      $display("FAIL happy_done_t: ctrl=%0d busy=%b done=%b error=%b, required 6 0 1 0",
               ctrl_t, busy_t, done_t, error_t);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({ctrl_a, done_a} !== {8'd6, 1'b1}) begin
      errors++;
      $display("FAIL happy_hold: ctrl=%0d done=%b, required 6 1", ctrl_a, done_a);
    end
  endtask

  task automatic test_image_gating;
    int bad = 0;
    set_lens(1, 3, 3, 3, 3, 3);
    img_ready = 1'b0;
    pulse_start();
    checks++;
    if ({ctrl_a, busy_a, done_a} !== {8'd1, 2'b10}) begin
      errors++;
      $display("FAIL gate_restart: ctrl=%0d busy=%b done=%b, required 1 1 0",
               ctrl_a, busy_a, done_a);
    end
    repeat (50) begin
      if (ctrl_a !== 8'd1) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL gate_hold: ctrl left 1 in %0d of 50 cycles, required 0", bad);
    end
    img_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ctrl_a !== 8'd2) begin
      errors++;
      $display("FAIL gate_release: ctrl=%0d, required 2", ctrl_a);
    end
    pulse_start();
    checks++;
    if ({ctrl_a, busy_a} !== {8'd2, 1'b1}) begin
      errors++;
      $display("FAIL start_in_run: ctrl=%0d busy=%b, required 2 1", ctrl_a, busy_a);
    end
    wait_done_a(100);
  endtask

  task automatic test_timeout;
    int n = 0;
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    set_lens(2, 2, 2, 1000, 3, 3);
    pulse_start();
    while (ctrl_t !== 8'd4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (ctrl_t === 8'd4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL timeout_len: %0d cycles in stage 4, required 16", n);
    end
    checks++;
    if ({error_t, err_stage_t, ctrl_t, busy_t} !== {1'b1, 3'd4, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL timeout_flags: error=%b err_stage=%0d ctrl=%0d busy=%b, required 1 4 0 0",
               error_t, err_stage_t, ctrl_t, busy_t);
    end
    checks++;
    if ({ctrl_a, error_a, busy_a} !== {8'd4, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL timeout_disabled: ctrl=%0d error=%b busy=%b, required 4 0 1",
               ctrl_a, error_a, busy_a);
    end
    repeat (5) @(negedge clk);
    checks++;
    if ({error_t, err_stage_t, ctrl_t} !== {1'b1, 3'd4, 8'd0}) begin
      errors++;
      $display("FAIL error_hold: error=%b err_stage=%0d ctrl=%0d, required 1 4 0",
               error_t, err_stage_t, ctrl_t);
    end
    pulse_start();
    checks++;
    if ({error_t, ctrl_t, busy_t} !== {1'b0, 8'd1, 1'b1}) begin
      errors++;
      $display("FAIL error_restart: error=%b ctrl=%0d busy=%b, required 0 1 1",
               error_t, ctrl_t, busy_t);
    end
  endtask

  task automatic test_abort;
    checks++;
    if (ctrl_a !== 8'd4) begin
      errors++;
      $display("FAIL abort_pre: ctrl=%0d, required 4", ctrl_a);
    end
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    checks++;
    if ({ctrl_a, busy_a, done_a, error_a} !== 11'd0) begin
      errors++;
      $display("FAIL abort_a: ctrl=%0d busy=%b done=%b error=%b, required all 0",
               ctrl_a, busy_a, done_a, error_a);
    end
    checks++;
    if ({ctrl_t, busy_t, error_t} !== 10'd0) begin
      errors++;
      $display("FAIL abort_t: ctrl=%0d busy=%b error=%b, required all 0", ctrl_t, busy_t, error_t);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({ctrl_a, busy_a} !== 9'd0) begin
      errors++;
      $display("FAIL abort_start_dropped: ctrl=%0d busy=%b, required 0 0", ctrl_a, busy_a);
    end
    set_lens(1, 1, 1, 1, 1, 1);
    pulse_start();
    wait_done_a(20);
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    checks++;
    if ({ctrl_a, done_a} !== 9'd0) begin
      errors++;
      $display("FAIL abort_from_done: ctrl=%0d done=%b, required 0 0", ctrl_a, done_a);
    end
  endtask

  task automatic test_async_reset;
    int n = 0;
    set_lens(3, 3, 3, 3, 3, 3);
    pulse_start();
    while (ctrl_a !== 8'd5 && n < 50) begin
      @(negedge clk);
      n++;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({ctrl_a, busy_a, ctrl_t, busy_t} !== 18'd0) begin
      errors++;
      $display("FAIL async_reset: ctrl_a=%0d busy_a=%b ctrl_t=%0d busy_t=%b, required all 0",
               ctrl_a, busy_a, ctrl_t, busy_t);
    end
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
  endtask

`ifdef CNN_SEQ_PERF_EN
  task automatic test_perf;
    int exp_perf [8] = '{0, 1, 10, 4, 20, 4, 7, 0};
    set_lens(1, 10, 4, 20, 4, 7);
    img_ready = 1'b1;
    pulse_start();
    wait_done_a(200);
    for (int s = 0; s < 8; s++) begin
      @(negedge clk) perf_sel = 3'(s);
      @(negedge clk);
      checks++;
      if (perf_count_a !== 32'(exp_perf[s])) begin
        errors++;
        $display("FAIL perf_sel %0d: count=%0d, required %0d", s, perf_count_a, exp_perf[s]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_happy_path();
    test_image_gating();
    test_timeout();
    test_abort();
    test_async_reset();
`ifdef CNN_SEQ_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnn_layer_sequencer.md
Name: cnn_layer_sequencer

Overview:
- Upstream driver of the CNN layer controller's 8-bit `ctrl` code.
- On a host `start`, steps `ctrl` through the stages in order: image load (1), conv1 (2), pool1 (3), conv2 (4), pool2 (5), FC (6).
- Advances only when the controller's `return_ctrl` echoes the current code. Then flags completion, timeout or abort to the host register interface.

Parameters:
- LAST_STAGE, 6: final `ctrl` code issued; legal range 1..6.
- TIMEOUT_CYCLES, 32'd1_000_000: maximum cycles spent in one stage; 0 disables the timeout.
- CNT_W, 32: width of the stage timeout counter and the perf counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to run the network.
- abort  in  1  single-cycle request to stop and return to idle.
- img_ready  in  1  host has finished writing the image memory.
- return_ctrl  in  8  stage-done echo from the layer controller.
- ctrl  out  8  registered stage code to the layer controller.
- busy  out  1  high while a run is in progress.
- done  out  1  sticky; run completed.
- error  out  1  sticky; stage timeout occurred.
- err_stage  out  3  stage code at which the timeout occurred.

Behaviour:
- Reset (async assert): state=IDLE, ctrl=0, busy=0, done=0, error=0, err_stage=0, stage counter=0, perf counters=0.
- All outputs are registered.
- States: IDLE, RUN, DONE, ERROR.
- IDLE:
  - ctrl=0.
  - start → RUN; ctrl=1 on the next cycle; busy=1; done and error cleared.
- RUN, advance condition: return_ctrl==ctrl, plus img_ready=1 when ctrl==1.
- RUN, on advance:
  - If ctrl<LAST_STAGE: ctrl←ctrl+1 next cycle; stage counter←0.
  - If ctrl==LAST_STAGE: state→DONE, done=1, busy=0.
- RUN, no advance:
  - Stage counter increments.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 without advance: →ERROR, error=1, err_stage=ctrl[2:0], ctrl=0, busy=0.
- Advance latency: one cycle from match to new ctrl. Each stage therefore lasts at least 1 cycle.
- The controller returns ctrl-1 while a stage is still running. A return_ctrl value that is neither ctrl nor ctrl-1 is treated as "not done". It is never a reason to go backwards.
- DONE:
  - ctrl held at LAST_STAGE so FC results stay valid for host readout.
  - start → RUN with ctrl=1, done cleared.
- ERROR:
  - ctrl=0; error and err_stage held.
  - start → RUN, error cleared.
- abort, in any state: →IDLE next cycle, ctrl=0, busy=0. done and error are cleared.
- abort and start in the same cycle: abort wins; start is dropped.
- start in RUN is ignored.
- Reset mid-run: immediate ctrl=0. This drives all controller memory resets high.

Optional Feature:
- Macro: CNN_SEQ_PERF_EN.
- When defined:
  - Adds input perf_sel[2:0] and output perf_count[CNT_W-1:0].
  - Six per-stage cycle counters record the cycles each stage spent in RUN during the latest run.
  - All six are cleared on a start that is accepted.
  - perf_count=counter[perf_sel-1]; perf_sel of 0 or >6 returns 0.
  - Each counter saturates at all-ones.
- When undefined: the ports and counters are absent; no other behaviour changes.

Decomposition:
- Package cnn_pkg:
  - Stage code constants: ST_IDLE=0, ST_IMG=1, ST_CONV1=2, ST_POOL1=3, ST_CONV2=4, ST_POOL2=5, ST_FC=6.
  - seq_state_t enum.
- These are shared with the layer controller and the host register block.
- Sub-module cnn_stage_timer: counter with clear, enable, saturate and limit-compare. It is used for the timeout and instantiated per stage for the perf counters.

Test Plan:
- Happy path: start with img_ready=1; the model echoes return_ctrl=ctrl after 3 cycles per stage → ctrl steps 1..6, done=1 after 6 stages, ctrl stays 6, busy=0.
- Image gating: img_ready=0 with return_ctrl=1 for 50 cycles → ctrl stays 1; raise img_ready → ctrl=2 on the next cycle.
- Timeout: TIMEOUT_CYCLES=16; the model holds return_ctrl=3 while ctrl=4 → error=1, err_stage=4, ctrl=0 after 16 cycles in stage 4.
- Abort: abort mid-conv2 (ctrl=4) asserted together with start → next cycle IDLE, ctrl=0, done=0, error=0; the start is ignored.
- Async reset: assert reset mid-cycle during ctrl=5 → ctrl=0 and busy=0 immediately, without waiting for a clock edge.
- Perf (CNN_SEQ_PERF_EN): stages take 1, 10, 4, 20, 4, 7 cycles → perf_sel 1..6 read back 1, 10, 4, 20, 4, 7; perf_sel=7 reads 0.
